// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared encodings for contador16 and its checkers
package contador_pkg;

    localparam int CONTADOR_WIDTH = 16;

    typedef enum logic [1:0] {
        MODO_UP   = 2'b00,
        MODO_DN   = 2'b01,
        MODO_DN3  = 2'b10,
        MODO_LOAD = 2'b11
    } modo_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } mon_state_t;

endpackage

// File: rtl/monitor_contador_if.sv
// rtl/monitor_contador_if.sv - tap and status bundle between contador16 and its monitor
interface monitor_contador_if #(
    parameter int WIDTH = contador_pkg::CONTADOR_WIDTH,
    parameter int CNT_W = 8
);
    logic             ENB;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] entrada;
    logic [WIDTH-1:0] salida;
    logic             RCO;
    logic             CLR;
    logic             VALID;
    logic             ERR_PULSE;
    logic             ERR;
    logic [CNT_W-1:0] ERR_CNT;
    logic [CNT_W-1:0] WRAP_CNT;
    logic [WIDTH-1:0] EXP_Q;

    modport slave (
        input  ENB, MODO, entrada, salida, RCO, CLR,
        output VALID, ERR_PULSE, ERR, ERR_CNT, WRAP_CNT, EXP_Q
    );

    modport master (
        output ENB, MODO, entrada, salida, RCO, CLR,
        input  VALID, ERR_PULSE, ERR, ERR_CNT, WRAP_CNT, EXP_Q
    );
endinterface

// File: rtl/modelo_contador.sv
// rtl/modelo_contador.sv - combinational golden model of one contador16 step
module modelo_contador
    import contador_pkg::*;
#(
    parameter int WIDTH = CONTADOR_WIDTH
) (
    input  logic             ENB,
    input  modo_t            MODO,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_next,
    output logic             RCO_next
);

    always_comb begin
        Q_next   = Q;
        RCO_next = 1'b0;
        if (ENB) begin
            case (MODO)
                MODO_UP: begin
                    Q_next   = Q + 1'b1;
                    RCO_next = &Q;
                end
                MODO_DN: begin
                    Q_next   = Q - 1'b1;
                    RCO_next = (Q == '0);
                end
                MODO_DN3: begin
                    Q_next   = Q - WIDTH'(3);
                    RCO_next = (Q < WIDTH'(3));
                end
                MODO_LOAD: begin
                    Q_next   = D;
                end
                default: begin
                    Q_next   = Q;
                end
            endcase
        end
    end

endmodule

// File: rtl/monitor_contador.sv
// rtl/monitor_contador.sv - predicts contador16 output each cycle and keeps error/wrap statistics
module monitor_contador
    import contador_pkg::*;
#(
    parameter int WIDTH = CONTADOR_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_L,
    monitor_contador_if.slave bus
);

    logic             r_prev_enb;
    modo_t            r_prev_modo;
    logic [WIDTH-1:0] r_prev_d;
    logic [WIDTH-1:0] r_prev_q;

    logic [WIDTH-1:0] w_exp_q;
    logic             w_exp_rco;
    logic             w_diff;
    logic             w_cmp;
    logic             w_mismatch;
    logic             w_wrap;

    mon_state_t       r_state;
    mon_state_t       w_state_nxt;

    logic             r_err_pulse;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_wrap_cnt;
    logic [WIDTH-1:0] r_exp_q;

    modelo_contador #(.WIDTH(WIDTH)) u_modelo (
        .ENB      (r_prev_enb),
        .MODO     (r_prev_modo),
        .D        (r_prev_d),
        .Q        (r_prev_q),
        .Q_next   (w_exp_q),
        .RCO_next (w_exp_rco)
    );

    // Prev registers always follow the real counter, which is what lets FAULT re-sync in one cycle.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_prev_enb  <= 1'b0;
            r_prev_modo <= MODO_UP;
            r_prev_d    <= '0;
            r_prev_q    <= '0;
        end else begin
            r_prev_enb  <= bus.ENB;
            r_prev_modo <= modo_t'(bus.MODO);
            r_prev_d    <= bus.entrada;
            r_prev_q    <= bus.salida;
        end
    end

    assign w_diff = (bus.salida != w_exp_q) || (bus.RCO != w_exp_rco);

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmp       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ENB) begin
                    w_state_nxt = TRACK;
                end
            end
            TRACK: begin
                w_cmp = 1'b1;
                if (w_diff) begin
                    w_state_nxt = FAULT;
                end
            end
            FAULT: begin
                w_state_nxt = TRACK;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_mismatch = w_cmp && w_diff;
    assign w_wrap     = w_cmp && !w_diff && w_exp_rco;

    // CLR wins over same-cycle updates, but the pulse still reports the mismatch.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_err_pulse <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_wrap_cnt  <= '0;
            r_exp_q     <= '0;
        end else begin
            r_err_pulse <= w_mismatch;
            if (bus.CLR) begin
                r_err      <= 1'b0;
                r_err_cnt  <= '0;
                r_wrap_cnt <= '0;
                r_exp_q    <= '0;
            end else begin
                if (w_mismatch) begin
                    r_err   <= 1'b1;
                    r_exp_q <= w_exp_q;
                    if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                end
                if (w_wrap && (r_wrap_cnt != '1)) begin
                    r_wrap_cnt <= r_wrap_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.VALID     = (r_state == TRACK);
    assign bus.ERR_PULSE = r_err_pulse;
    assign bus.ERR       = r_err;
    assign bus.ERR_CNT   = r_err_cnt;
    assign bus.WRAP_CNT  = r_wrap_cnt;
    assign bus.EXP_Q     = r_exp_q;

endmodule

// File: tb/tb_monitor_contador.sv
// tb/tb_monitor_contador.sv - directed vector bench for monitor_contador
module tb_monitor_contador;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    monitor_contador_if #(.WIDTH(16), .CNT_W(8)) bus ();

    monitor_contador #(.WIDTH(16), .CNT_W(8)) dut (
        .CLK     (clk),
        .RESET_L (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        enb;
        logic [1:0]  modo;
        logic [15:0] ent;
        logic [15:0] sal;
        logic        rco;
        logic        clr;
        logic        valid;
        logic        pulse;
        logic        err;
        logic [7:0]  ecnt;
        logic [7:0]  wcnt;
        logic [15:0] expq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic enb, input logic [1:0] modo, input logic [15:0] ent,
                       input logic [15:0] sal, input logic rco, input logic clr,
                       input logic valid, input logic pulse, input logic err,
                       input logic [7:0] ecnt, input logic [7:0] wcnt, input logic [15:0] expq);
        vec_t v;
        v.enb = enb; v.modo = modo; v.ent = ent; v.sal = sal; v.rco = rco; v.clr = clr;
        v.valid = valid; v.pulse = pulse; v.err = err; v.ecnt = ecnt; v.wcnt = wcnt; v.expq = expq;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic drive(input logic enb, input logic [1:0] modo, input logic [15:0] ent,
                         input logic [15:0] sal, input logic rco, input logic clr);
        bus.ENB = enb; bus.MODO = modo; bus.entrada = ent;
        bus.salida = sal; bus.RCO = rco; bus.CLR = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic valid, input logic pulse, input logic err,
                           input logic [7:0] ecnt, input logic [7:0] wcnt, input logic [15:0] expq);
        chk({tag, ".valid"}, 16'(bus.VALID), 16'(valid));
        chk({tag, ".pulse"}, 16'(bus.ERR_PULSE), 16'(pulse));
        chk({tag, ".err"}, 16'(bus.ERR), 16'(err));
        chk({tag, ".err_cnt"}, 16'(bus.ERR_CNT), 16'(ecnt));
        chk({tag, ".wrap_cnt"}, 16'(bus.WRAP_CNT), 16'(wcnt));
        chk({tag, ".exp_q"}, bus.EXP_Q, expq);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);

        //   enb modo ent      sal      rco clr | valid pulse err ecnt wcnt expq
        add(1, 2'd3, 16'hFFFC, 16'h0000, 0, 0,  1, 0, 0, 8'd0, 8'd0, 16'h0000);
        add(1, 2'd0, 16'h0000, 16'hFFFC, 0, 0,  1, 0, 0, 8'd0, 8'd0, 16'h0000);
        add(1, 2'd0, 16'h0000, 16'hFFFD, 0, 0,  1, 0, 0, 8'd0, 8'd0, 16'h0000);
        add(1, 2'd0, 16'h0000, 16'hFFFE, 0, 0,  1, 0, 0, 8'd0, 8'd0, 16'h0000);
        add(1, 2'd0, 16'h0000, 16'hFFFF, 0, 0,  1, 0, 0, 8'd0, 8'd0, 16'h0000);
        add(1, 2'd0, 16'h0000, 16'h0000, 1, 0,  1, 0, 0, 8'd0, 8'd1, 16'h0000);
        add(1, 2'd0, 16'h0000, 16'h0001, 0, 0,  1, 0, 0, 8'd0, 8'd1, 16'h0000);
        add(1, 2'd3, 16'h0002, 16'h0002, 0, 0,  1, 0, 0, 8'd0, 8'd1, 16'h0000);
        add(1, 2'd2, 16'h0000, 16'h0002, 0, 0,  1, 0, 0, 8'd0, 8'd1, 16'h0000);
        add(1, 2'd2, 16'h0000, 16'hFFFF, 1, 0,  1, 0, 0, 8'd0, 8'd2, 16'h0000);
        add(1, 2'd3, 16'h1233, 16'hFFFC, 0, 0,  1, 0, 0, 8'd0, 8'd2, 16'h0000);
        add(1, 2'd0, 16'h0000, 16'h1233, 0, 0,  1, 0, 0, 8'd0, 8'd2, 16'h0000);
        add(1, 2'd0, 16'h0000, 16'h1235, 0, 0,  0, 1, 1, 8'd1, 8'd2, 16'h1234);
        add(1, 2'd0, 16'h0000, 16'h1235, 0, 0,  1, 0, 1, 8'd1, 8'd2, 16'h1234);
        add(1, 2'd3, 16'hFFFF, 16'h1236, 0, 0,  1, 0, 1, 8'd1, 8'd2, 16'h1234);
        add(1, 2'd0, 16'h0000, 16'hFFFF, 0, 0,  1, 0, 1, 8'd1, 8'd2, 16'h1234);
        add(1, 2'd0, 16'h0000, 16'h0000, 0, 0,  0, 1, 1, 8'd2, 8'd2, 16'h0000);
        add(1, 2'd0, 16'h0000, 16'h0001, 0, 0,  1, 0, 1, 8'd2, 8'd2, 16'h0000);
        add(1, 2'd0, 16'h0000, 16'h0002, 0, 1,  1, 0, 0, 8'd0, 8'd0, 16'h0000);
        add(1, 2'd0, 16'h0000, 16'h0009, 0, 1,  0, 1, 0, 8'd0, 8'd0, 16'h0000);
        add(1, 2'd3, 16'h0000, 16'h000A, 0, 0,  1, 0, 0, 8'd0, 8'd0, 16'h0000);
        add(1, 2'd1, 16'h0000, 16'h0000, 0, 0,  1, 0, 0, 8'd0, 8'd0, 16'h0000);
        add(0, 2'd1, 16'h0000, 16'hFFFF, 1, 1,  1, 0, 0, 8'd0, 8'd0, 16'h0000);
        add(0, 2'd1, 16'h0000, 16'hFFFF, 0, 0,  1, 0, 0, 8'd0, 8'd0, 16'h0000);
        add(0, 2'd1, 16'h0000, 16'hFFFF, 1, 0,  0, 1, 1, 8'd1, 8'd0, 16'hFFFF);
        add(0, 2'd1, 16'h0000, 16'hFFFF, 0, 0,  1, 0, 1, 8'd1, 8'd0, 16'hFFFF);
        add(1, 2'd0, 16'h0000, 16'hFFFF, 0, 0,  1, 0, 1, 8'd1, 8'd0, 16'hFFFF);
        add(1, 2'd0, 16'h0000, 16'h0000, 1, 0,  1, 0, 1, 8'd1, 8'd1, 16'hFFFF);

        step();
        step();
        chk_all("reset", 0, 0, 0, 8'd0, 8'd0, 16'h0000);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].enb, tbl[i].modo, tbl[i].ent, tbl[i].sal, tbl[i].rco, tbl[i].clr);
            step();
            chk_all($sformatf("row%0d", i), tbl[i].valid, tbl[i].pulse, tbl[i].err,
                    tbl[i].ecnt, tbl[i].wcnt, tbl[i].expq);
        end

        // Stuck output: every TRACK cycle mismatches, so 600 cycles give 300 errors.
        drive(1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) step();
        chk("sat.err_cnt", 16'(bus.ERR_CNT), 16'd255);
        chk("sat.err", 16'(bus.ERR), 16'd1);
        chk("sat.wrap_cnt", 16'(bus.WRAP_CNT), 16'd1);
        bus.CLR = 1'b1;
        step();
        bus.CLR = 1'b0;
        chk("clr.err", 16'(bus.ERR), 16'd0);
        chk("clr.err_cnt", 16'(bus.ERR_CNT), 16'd0);
        chk("clr.wrap_cnt", 16'(bus.WRAP_CNT), 16'd0);
        chk("clr.exp_q", bus.EXP_Q, 16'h0000);

        // Re-establish correct tracking, then reset asynchronously mid-count.
        drive(1'b1, 2'd3, 16'h0100, 16'h0000, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'd0, 16'h0000, 16'h0100, 1'b0, 1'b0);
        step();
        bus.salida = 16'h0101;
        step();
        bus.salida = 16'h0102;
        step();
        chk("track.valid", 16'(bus.VALID), 16'd1);
        chk("track.pulse", 16'(bus.ERR_PULSE), 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 8'd0, 8'd0, 16'h0000);
        step();
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 16'h0000, 16'hDEAD, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("idle%0d.valid", i), 16'(bus.VALID), 16'd0);
            chk($sformatf("idle%0d.pulse", i), 16'(bus.ERR_PULSE), 16'd0);
        end
        drive(1'b1, 2'd0, 16'h0000, 16'hDEAD, 1'b0, 1'b0);
        step();
        chk("resume.valid", 16'(bus.VALID), 16'd1);
        chk("resume.err_cnt", 16'(bus.ERR_CNT), 16'd0);
        bus.salida = 16'hDEAE;
        step();
        chk("resume2.valid", 16'(bus.VALID), 16'd1);
        chk("resume2.pulse", 16'(bus.ERR_PULSE), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
